// File: rtl/rd_tlp_axi_if.sv
// rtl/rd_tlp_axi_if.sv - request TLP, AXI4 read and completion TLP signal bundle for rd_tlp_axi
interface rd_tlp_axi_if;
    logic [127:0] tlp_hdr;
    logic [255:0] tlp_data;
    logic         tlp_sop;
    logic         tlp_eop;
    logic         tlp_valid;
    logic         tlp_ready;

    logic [7:0]   axi_arid;
    logic [63:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic         axi_arvalid;
    logic         axi_arready;

    logic [7:0]   axi_rid;
    logic [255:0] axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;

    logic [127:0] cpl_hdr;
    logic [255:0] cpl_data;
    logic         cpl_sop;
    logic         cpl_eop;
    logic         cpl_valid;
    logic         cpl_ready;

    logic         tlp_error;

    modport slave (
        input  tlp_hdr, tlp_data, tlp_sop, tlp_eop, tlp_valid,
        output tlp_ready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready,
        output cpl_hdr, cpl_data, cpl_sop, cpl_eop, cpl_valid,
        input  cpl_ready,
        output tlp_error
    );

    modport master (
        output tlp_hdr, tlp_data, tlp_sop, tlp_eop, tlp_valid,
        input  tlp_ready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready,
        input  cpl_hdr, cpl_data, cpl_sop, cpl_eop, cpl_valid,
        output cpl_ready,
        input  tlp_error
    );
endinterface

// File: rtl/rd_tlp_axi.sv
// rtl/rd_tlp_axi.sv - MRd request TLP to single AXI4 INCR read burst, R beats streamed out as CplD
module rd_tlp_axi #(
    parameter int          DOUBLE_WORD       = 32,
    parameter int          HEADER_SIZE       = 128,
    parameter int          TLP_DATA_WIDTH    = 256,
    parameter int          AXI_DATA_WIDTH    = 256,
    parameter int          AXI_ADDR_WIDTH    = 64,
    parameter int          AXI_ID_WIDTH      = 8,
    parameter int          AXI_MAX_BURST_LEN = 256,
    parameter logic [15:0] COMPLETER_ID      = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    rd_tlp_axi_if.slave  bus
);
    localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BEAT_LOG2   = $clog2(BEAT_BYTES);
    localparam int DW_PER_BEAT = AXI_DATA_WIDTH / DOUBLE_WORD;
    localparam int BEAT_SHIFT  = $clog2(DW_PER_BEAT);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA} state_t;

    state_t                    state_q;
    logic                      tlp_ready_q, arvalid_q, tlp_error_q, first_q;
    logic [2:0]                status_q, arsize_q;
    logic [1:0]                arburst_q;
    logic [7:0]                arlen_q;
    logic [AXI_ID_WIDTH-1:0]   arid_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [HEADER_SIZE-1:0]    cpl_hdr_q;

    logic [2:0]                fmt;
    logic [4:0]                typ;
    logic [9:0]                len;
    logic [63:0]               req_addr;
    logic [10:0]               len_dw;
    logic [11:0]               span, beats;
    logic                      req_ok_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_d;
    logic [7:0]                arlen_d;
    logic [HEADER_SIZE-1:0]    cpl_hdr_d, hdr_out;
    logic [2:0]                status;
    logic                      in_data, beat_fire, resp_bad;
    logic [TLP_DATA_WIDTH-1:0] beat_data;

    assign fmt = bus.tlp_hdr[31:29];
    assign typ = bus.tlp_hdr[28:24];
    assign len = bus.tlp_hdr[9:0];

    always_comb begin
        req_addr = {32'b0, bus.tlp_hdr[95:66], 2'b00};
        if (fmt == 3'b001)
            req_addr = {bus.tlp_hdr[95:64], bus.tlp_hdr[127:98], 2'b00};
    end

    // Beats covered by the request once its DW offset inside the first beat is added.
    assign len_dw   = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    assign span     = 12'(req_addr[BEAT_LOG2-1:2]) + {1'b0, len_dw};
    assign beats    = (span + 12'(DW_PER_BEAT - 1)) >> BEAT_SHIFT;
    assign req_ok_d = (typ == 5'b00000) && (fmt == 3'b000 || fmt == 3'b001)
                      && (beats <= 12'(AXI_MAX_BURST_LEN));
    assign araddr_d = AXI_ADDR_WIDTH'(req_addr) & ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
    assign arlen_d  = 8'(beats - 12'd1);

    always_comb begin
        cpl_hdr_d        = '0;
        cpl_hdr_d[31:29] = 3'b010;
        cpl_hdr_d[28:24] = 5'b01010;
        cpl_hdr_d[9:0]   = len;
        cpl_hdr_d[63:48] = COMPLETER_ID;
        cpl_hdr_d[43:32] = {len, 2'b00};
        cpl_hdr_d[95:80] = bus.tlp_hdr[63:48];
        cpl_hdr_d[79:72] = bus.tlp_hdr[47:40];
        cpl_hdr_d[70:64] = req_addr[6:0];
    end

    assign in_data   = (state_q == S_DATA);
    assign beat_fire = in_data && bus.axi_rvalid && bus.cpl_ready;
    assign resp_bad  = (bus.axi_rresp != 2'b00);

    // Completion status follows the first beat's rresp live, then holds the latched value.
    assign status = (in_data && first_q && bus.axi_rvalid && resp_bad) ? 3'b100 : status_q;

    always_comb begin
        hdr_out        = cpl_hdr_q;
        hdr_out[47:45] = status;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tlp_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            tlp_error_q <= 1'b0;
            first_q     <= 1'b0;
            status_q    <= 3'b000;
            arsize_q    <= 3'b000;
            arburst_q   <= 2'b00;
            arlen_q     <= 8'd0;
            arid_q      <= '0;
            araddr_q    <= '0;
            cpl_hdr_q   <= '0;
        end else begin
            tlp_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tlp_ready_q <= 1'b1;
                    if (bus.tlp_valid && tlp_ready_q) begin
                        if (req_ok_d) begin
                            state_q     <= S_AR;
                            tlp_ready_q <= 1'b0;
                            arvalid_q   <= 1'b1;
                            araddr_q    <= araddr_d;
                            arlen_q     <= arlen_d;
                            arid_q      <= AXI_ID_WIDTH'(bus.tlp_hdr[47:40]);
                            arsize_q    <= 3'(BEAT_LOG2);
                            arburst_q   <= 2'b01;
                            cpl_hdr_q   <= cpl_hdr_d;
                            status_q    <= 3'b000;
                            first_q     <= 1'b1;
                        end else begin
                            tlp_error_q <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (bus.axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat_fire) begin
                        first_q <= 1'b0;
                        if (first_q && resp_bad)
                            status_q <= 3'b100;
                        if (bus.axi_rlast) begin
                            state_q     <= S_IDLE;
                            tlp_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign beat_data       = bus.axi_rdata;
    assign bus.tlp_ready   = tlp_ready_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_araddr  = araddr_q;
    assign bus.axi_arlen   = arlen_q;
    assign bus.axi_arid    = arid_q;
    assign bus.axi_arsize  = arsize_q;
    assign bus.axi_arburst = arburst_q;
    assign bus.axi_rready  = in_data && bus.cpl_ready;
    assign bus.cpl_valid   = in_data && bus.axi_rvalid;
    assign bus.cpl_data    = beat_data;
    assign bus.cpl_sop     = in_data && first_q;
    assign bus.cpl_eop     = in_data && bus.axi_rlast;
    assign bus.cpl_hdr     = hdr_out;
    assign bus.tlp_error   = tlp_error_q || (beat_fire && resp_bad);

    logic unused_bits;
    assign unused_bits = ^{bus.axi_rid, bus.tlp_data, bus.tlp_sop, bus.tlp_eop,
                           bus.tlp_hdr[23:10], bus.tlp_hdr[39:32], bus.tlp_hdr[97:96]};
endmodule
